// File: rtl/usb_uart_pkg.sv
// Shared constants and framer state encoding for the USB CDC byte-stream bridge.
package usb_uart_pkg;

    localparam int unsigned DEF_FIFO_DEPTH   = 64;
    localparam int unsigned DEF_MAX_PKT      = 64;
    localparam int unsigned DEF_FLUSH_CYCLES = 48000;
    localparam int unsigned BYTE_W           = 8;

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_SEND = 1'b1
    } framer_state_t;

    // Smaller of two unsigned values; used to size a packet from FIFO occupancy.
    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_uart_pipe_if.sv
// Valid/ready byte channels between the application, the bridge and the USB endpoint engine.
interface usb_uart_pipe_if;

    logic [7:0] uart_in_data;
    logic       uart_in_valid;
    logic       uart_in_ready;

    logic [7:0] uart_out_data;
    logic       uart_out_valid;
    logic       uart_out_ready;

    logic [7:0] in_ep_data;
    logic       in_ep_valid;
    logic       in_ep_last;
    logic       in_ep_ready;

    logic [7:0] out_ep_data;
    logic       out_ep_valid;
    logic       out_ep_ready;

    // Bridge side
    modport slave (
        input  uart_in_data, uart_in_valid,
        output uart_in_ready,
        output uart_out_data, uart_out_valid,
        input  uart_out_ready,
        output in_ep_data, in_ep_valid, in_ep_last,
        input  in_ep_ready,
        input  out_ep_data, out_ep_valid,
        output out_ep_ready
    );

    // Application / USB engine side
    modport master (
        output uart_in_data, uart_in_valid,
        input  uart_in_ready,
        input  uart_out_data, uart_out_valid,
        output uart_out_ready,
        input  in_ep_data, in_ep_valid, in_ep_last,
        output in_ep_ready,
        output out_ep_data, out_ep_valid,
        input  out_ep_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered occupancy, full and empty flags; head is a combinational read.
module sync_fifo #(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head_c,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_nxt;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage is not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/usb_uart_pipe.sv
// Byte-stream bridge between UART-style pipelines and the USB CDC bulk endpoints,
// framing device-to-host bytes into bulk-IN packets closed by size or idle timeout.
module usb_uart_pipe
    import usb_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned MAX_PKT      = DEF_MAX_PKT,
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic           clk_48mhz,
    input  logic           reset,
    usb_uart_pipe_if.slave bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned RW = $clog2(MAX_PKT + 1);

    framer_state_t state;
    framer_state_t state_nxt;
    logic [RW-1:0] remaining;
    logic [RW-1:0] remaining_nxt;
    logic          pkt_done_c;
    logic [TW-1:0] idle_timer;

    logic          in_push;
    logic          in_pop;
    logic          in_full;
    logic          in_empty;
    logic [CW-1:0] in_count;
    logic [7:0]    in_head_c;

    logic          out_push;
    logic          out_pop;
    logic          out_full;
    logic          out_empty;
    logic [CW-1:0] out_count_unused;
    logic [7:0]    out_head_c;
    logic [7:0]    out_data_q;
    logic          out_valid_q;

    // ---------------- device-to-host path ----------------
    assign bus.uart_in_ready = !in_full && !reset;
    assign in_push           = bus.uart_in_valid && bus.uart_in_ready;
    assign in_pop            = (state == FR_SEND) && bus.in_ep_ready;

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk       (clk_48mhz),
        .rst       (reset),
        .push      (in_push),
        .push_data (bus.uart_in_data),
        .pop       (in_pop),
        .head_c    (in_head_c),
        .count     (in_count),
        .full      (in_full),
        .empty     (in_empty)
    );

    assign bus.in_ep_valid = (state == FR_SEND);
    assign bus.in_ep_last  = (state == FR_SEND) && (remaining == RW'(1));
    assign bus.in_ep_data  = (state == FR_SEND) ? in_head_c : 8'h00;

    // Framer: a packet is sized once on entry to SEND, so later pushes wait for the next packet.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pkt_done_c    = 1'b0;
        case (state)
            FR_IDLE: begin
                if ((in_count >= CW'(MAX_PKT)) ||
                    (!in_empty && (idle_timer >= TW'(FLUSH_CYCLES)))) begin
                    state_nxt     = FR_SEND;
                    remaining_nxt = RW'(min_u(32'(in_count), MAX_PKT));
                end
            end
            FR_SEND: begin
                if (bus.in_ep_ready) begin
                    remaining_nxt = remaining - RW'(1);
                    if (remaining == RW'(1)) begin
                        state_nxt  = FR_IDLE;
                        pkt_done_c = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state     <= FR_IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Idle timer counts quiet IDLE cycles with data pending and saturates at the flush threshold.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            idle_timer <= '0;
        end else if (in_push || in_empty || pkt_done_c) begin
            idle_timer <= '0;
        end else if ((state == FR_IDLE) && (idle_timer < TW'(FLUSH_CYCLES))) begin
            idle_timer <= idle_timer + TW'(1);
        end
    end

    // ---------------- host-to-device path ----------------
    assign bus.out_ep_ready = !out_full && !reset;
    assign out_push         = bus.out_ep_valid && bus.out_ep_ready;
    assign out_pop          = !out_empty && (!out_valid_q || bus.uart_out_ready);

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk       (clk_48mhz),
        .rst       (reset),
        .push      (out_push),
        .push_data (bus.out_ep_data),
        .pop       (out_pop),
        .head_c    (out_head_c),
        .count     (out_count_unused),
        .full      (out_full),
        .empty     (out_empty)
    );

    // Output register keeps the last delivered byte visible after valid drops.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else if (out_pop) begin
            out_data_q  <= out_head_c;
            out_valid_q <= 1'b1;
        end else if (bus.uart_out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.uart_out_data  = out_data_q;
    assign bus.uart_out_valid = out_valid_q;

endmodule

// File: tb/tb_usb_uart_pipe.sv
// Randomized scoreboard bench for usb_uart_pipe: expected bytes are queued on issue, a monitor checks them on delivery.
module tb_usb_uart_pipe;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned MAXP  = 64;
    localparam int unsigned FLUSH = 300;

    logic clk_48mhz = 1'b0;
    logic reset     = 1'b1;

    always #5 clk_48mhz = ~clk_48mhz;

    usb_uart_pipe_if bus ();

    usb_uart_pipe #(
        .FIFO_DEPTH   (DEPTH),
        .MAX_PKT      (MAXP),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int in_xfers = 0;
    int in_rdy_mode  = 1;   // 0: never, 1: always, 2: random
    int out_rdy_mode = 0;

    logic [8:0] in_exp  [$];  // {last, data}
    logic [7:0] out_exp [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h expected nothing", name, act);
    endtask

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    // Sink-side ready generators
    always @(posedge clk_48mhz) begin
        #2;
        bus.in_ep_ready    = (in_rdy_mode == 2)  ? ($urandom_range(0, 3) != 0) : (in_rdy_mode == 1);
        bus.uart_out_ready = (out_rdy_mode == 2) ? ($urandom_range(0, 2) != 0) : (out_rdy_mode == 1);
    end

    // Monitor: every transfer about to happen is compared with the head of its queue.
    always @(negedge clk_48mhz) begin
        logic [8:0] ei;
        logic [7:0] eo;
        if (!reset) begin
            if (bus.in_ep_valid && bus.in_ep_ready) begin
                in_xfers++;
                if (in_exp.size() == 0) fail_now("in_ep unexpected byte", 32'({bus.in_ep_last, bus.in_ep_data}));
                else begin
                    ei = in_exp.pop_front();
                    check("in_ep {last,data}", 32'({bus.in_ep_last, bus.in_ep_data}), 32'(ei));
                end
            end
            if (bus.uart_out_valid && bus.uart_out_ready) begin
                if (out_exp.size() == 0) fail_now("uart_out unexpected byte", 32'(bus.uart_out_data));
                else begin
                    eo = out_exp.pop_front();
                    check("uart_out data", 32'(bus.uart_out_data), 32'(eo));
                end
            end
        end
    end

    task automatic in_push(input logic [7:0] b, input logic last_e, output logic ok);
        logic r;
        ok = 1'b0;
        bus.uart_in_data  = b;
        bus.uart_in_valid = 1'b1;
        for (int k = 0; k < 4000 && !ok; k++) begin
            @(negedge clk_48mhz);
            r = bus.uart_in_ready;
            @(posedge clk_48mhz);
            if (r) begin
                ok = 1'b1;
                in_exp.push_back({last_e, b});
            end
            #1;
        end
        if (!ok) fail_now("uart_in push timeout", 32'(b));
    endtask

    task automatic out_push(input logic [7:0] b, input int budget, output logic ok);
        logic r;
        ok = 1'b0;
        bus.out_ep_data  = b;
        bus.out_ep_valid = 1'b1;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk_48mhz);
            r = bus.out_ep_ready;
            @(posedge clk_48mhz);
            if (r) begin
                ok = 1'b1;
                out_exp.push_back(b);
            end
            #1;
        end
    endtask

    // A burst is cut into MAXP-byte packets, with any remainder flushed as a short packet.
    task automatic in_burst(input int n);
        logic ok;
        for (int i = 0; i < n; i++) begin
            in_push(8'($urandom), (((i + 1) % MAXP) == 0) || (i == n - 1), ok);
            if ($urandom_range(0, 3) == 0) begin
                bus.uart_in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        bus.uart_in_valid = 1'b0;
    endtask

    task automatic out_stream(input int n);
        logic ok;
        for (int i = 0; i < n; i++) begin
            out_push(8'($urandom), 4000, ok);
            if (!ok) fail_now("out_ep push timeout", 32'(i));
            if ($urandom_range(0, 3) == 0) begin
                bus.out_ep_valid = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
            end
        end
        bus.out_ep_valid = 1'b0;
    endtask

    task automatic wait_in_drain(input int budget, input string name);
        int k = 0;
        while (in_exp.size() != 0 && k < budget) begin tick(); k++; end
        check(name, 32'(in_exp.size()), 32'd0);
    endtask

    task automatic wait_out_drain(input int budget, input string name);
        int k = 0;
        while (out_exp.size() != 0 && k < budget) begin tick(); k++; end
        check(name, 32'(out_exp.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic  ok;
        int    k;
        int    base;
        string hello;

        bus.uart_in_data   = 8'h00;
        bus.uart_in_valid  = 1'b0;
        bus.out_ep_data    = 8'h00;
        bus.out_ep_valid   = 1'b0;
        bus.in_ep_ready    = 1'b0;
        bus.uart_out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk_48mhz);
        #1;
        check("rst uart_in_ready",  32'(bus.uart_in_ready),  32'd0);
        check("rst out_ep_ready",   32'(bus.out_ep_ready),   32'd0);
        check("rst uart_out_valid", 32'(bus.uart_out_valid), 32'd0);
        check("rst uart_out_data",  32'(bus.uart_out_data),  32'd0);
        check("rst in_ep_valid",    32'(bus.in_ep_valid),    32'd0);
        check("rst in_ep_last",     32'(bus.in_ep_last),     32'd0);
        check("rst in_ep_data",     32'(bus.in_ep_data),     32'd0);
        reset = 1'b0;
        #1;
        check("post-rst uart_in_ready", 32'(bus.uart_in_ready), 32'd1);
        check("post-rst out_ep_ready",  32'(bus.out_ep_ready),  32'd1);
        tick();
        check("post-rst uart_out_valid", 32'(bus.uart_out_valid), 32'd0);
        check("post-rst uart_out_data",  32'(bus.uart_out_data),  32'd0);
        check("post-rst in_ep_valid",    32'(bus.in_ep_valid),    32'd0);

        // Partial packet flushed after the idle timeout
        in_rdy_mode = 1;
        hello = "Hello World!\r\n";
        for (int i = 0; i < hello.len(); i++) in_push(hello[i], i == hello.len() - 1, ok);
        bus.uart_in_valid = 1'b0;
        k = 0;
        while (!bus.in_ep_valid && k < int'(FLUSH) + 50) begin tick(); k++; end
        check("partial flush latency", 32'(k), 32'(FLUSH + 1));
        wait_in_drain(200, "hello drain");

        // 130 bytes: two full packets then a 2-byte flush
        for (int i = 0; i < 130; i++) begin
            in_push(8'(i + 1), (((i + 1) % MAXP) == 0) || (i == 129), ok);
            if (i == int'(MAXP) - 1) begin
                bus.uart_in_valid = 1'b0;
                check("full pkt not yet valid", 32'(bus.in_ep_valid), 32'd0);
                tick();
                check("full pkt latency", 32'(bus.in_ep_valid), 32'd1);
            end
        end
        bus.uart_in_valid = 1'b0;
        wait_in_drain(int'(FLUSH) + 400, "130 drain");

        // Single OUT byte through the output register
        out_rdy_mode = 0;
        repeat (2) tick();
        out_push(8'h61, 20, ok);
        bus.out_ep_valid = 1'b0;
        check("out 'a' accepted", 32'(ok), 32'd1);
        check("out valid before N+1", 32'(bus.uart_out_valid), 32'd0);
        tick();
        check("out valid at N+1", 32'(bus.uart_out_valid), 32'd1);
        check("out data at N+1",  32'(bus.uart_out_data),  32'h61);
        out_rdy_mode = 1;
        tick();
        out_rdy_mode = 0;
        check("out valid after accept", 32'(bus.uart_out_valid), 32'd0);
        check("out data held",          32'(bus.uart_out_data),  32'h61);
        repeat (2) tick();

        // Fill out-FIFO plus register, then reject one more
        for (int i = 0; i < 65; i++) begin
            out_push(8'(8'h80 + i), 20, ok);
            if (!ok) fail_now("fill push refused", 32'(i));
        end
        check("out_ep_ready when full", 32'(bus.out_ep_ready), 32'd0);
        out_push(8'hEE, 8, ok);
        bus.out_ep_valid = 1'b0;
        check("66th byte rejected", 32'(ok), 32'd0);
        out_rdy_mode = 1;
        wait_out_drain(300, "fill drain");

        // Randomized traffic in both directions
        in_rdy_mode  = 2;
        out_rdy_mode = 2;
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    in_burst($urandom_range(1, 200));
                    wait_in_drain(int'(FLUSH) + 4000, "random burst drain");
                end
            end
            out_stream(300);
        join
        wait_out_drain(2000, "random out drain");

        // Reset in the middle of a packet
        in_rdy_mode  = 1;
        out_rdy_mode = 0;
        for (int i = 0; i < 3; i++) out_push(8'(8'h30 + i), 20, ok);
        bus.out_ep_valid = 1'b0;
        base = in_xfers;
        for (int i = 0; i < 64; i++) in_push(8'(8'h40 + i), i == 63, ok);
        bus.uart_in_valid = 1'b0;
        k = 0;
        while (in_xfers < base + 10 && k < 500) begin tick(); k++; end
        check("mid-send byte count", 32'(in_xfers - base), 32'd10);
        reset = 1'b1;
        #1;
        check("mid rst in_ep_valid",   32'(bus.in_ep_valid),   32'd0);
        check("mid rst in_ep_last",    32'(bus.in_ep_last),    32'd0);
        check("mid rst in_ep_data",    32'(bus.in_ep_data),    32'd0);
        check("mid rst uart_in_ready", 32'(bus.uart_in_ready), 32'd0);
        check("mid rst out_ep_ready",  32'(bus.out_ep_ready),  32'd0);
        in_exp.delete();
        out_exp.delete();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("mid rst release uart_in_ready", 32'(bus.uart_in_ready), 32'd1);
        out_rdy_mode = 2;
        repeat (int'(FLUSH) + 30) tick();
        check("in-FIFO empty after reset",  32'(in_xfers - base), 32'd10);
        check("out-FIFO empty after reset", 32'(bus.uart_out_valid), 32'd0);
        check("in_ep idle after reset",     32'(bus.in_ep_valid),    32'd0);

        check("in queue empty at end",  32'(in_exp.size()),  32'd0);
        check("out queue empty at end", 32'(out_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
